// File: rtl/bp_be_pkg.sv
// Shared types for the BE side of the FE queue: packet layout and checkpoint pointer.
package bp_be_pkg;

  localparam int vaddr_width_gp  = 39;
  localparam int instr_width_gp  = 32;
  localparam int fe_queue_els_gp = 8;

  typedef enum logic [0:0] {
    e_fe_fetch     = 1'b0,
    e_fe_exception = 1'b1
  } bp_fe_queue_type_e;

  typedef struct packed {
    bp_fe_queue_type_e           msg_type;
    logic [vaddr_width_gp-1:0]   pc;
    logic [instr_width_gp-1:0]   instr;
  } bp_fe_queue_s;

  localparam int fe_queue_width_lp = $bits(bp_fe_queue_s);

  // One extra bit above the index acts as the wrap bit for full/empty.
  function automatic int ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

  typedef logic [$clog2(fe_queue_els_gp):0] bp_be_ckpt_ptr_t;

endpackage

// File: rtl/bp_be_fe_queue_ptr.sv
// Single wrapping queue pointer; a load (set) takes priority over an increment.
module bp_be_fe_queue_ptr
  import bp_be_pkg::*;
#(
  parameter int ptr_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   inc_i,
  input  logic                   set_v_i,
  input  logic [ptr_width_p-1:0] set_val_i,
  output logic [ptr_width_p-1:0] ptr_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_o <= '0;
    end else if (set_v_i) begin
      ptr_o <= set_val_i;
    end else if (inc_i) begin
      ptr_o <= ptr_o + ptr_width_p'(1);
    end
  end

endmodule

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointing FE->BE queue: speculative read pointer, commit pointer, rollback and clear.
module bp_be_fe_queue_ckpt
  import bp_be_pkg::*;
#(
  parameter int els_p        = 8,
  parameter int data_width_p = fe_queue_width_lp,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [data_width_p-1:0] fe_queue_i,
  input  logic                    fe_queue_v_i,
  output logic                    fe_queue_ready_o,
  output logic [data_width_p-1:0] fe_queue_o,
  output logic                    fe_queue_v_o,
  input  logic                    fe_queue_yumi_i,
  input  logic                    fe_queue_clr_i,
  input  logic                    fe_queue_roll_i,
  input  logic                    fe_queue_deq_i
);

  logic [ptr_width_lp-1:0] wptr, rptr, cptr, rptr_n;
  logic [data_width_p-1:0] mem [els_p];
  logic                    full, enq, cptr_inc;

  assign full             = (wptr ^ cptr) == {1'b1, {(ptr_width_lp-1){1'b0}}};
  assign fe_queue_ready_o = ~full;
  assign fe_queue_v_o     = (rptr != wptr);
  assign fe_queue_o       = mem[rptr[ptr_width_lp-2:0]];

  assign enq      = fe_queue_v_i & ~full;
  // Roll overrides both yumi and deq; clear then snaps wptr onto the next rptr.
  assign rptr_n   = fe_queue_roll_i ? cptr
                  : fe_queue_yumi_i ? rptr + ptr_width_lp'(1)
                  : rptr;
  assign cptr_inc = fe_queue_deq_i & ~fe_queue_roll_i;

  bp_be_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) u_wptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (enq),
    .set_v_i   (fe_queue_clr_i),
    .set_val_i (rptr_n),
    .ptr_o     (wptr)
  );

  bp_be_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) u_rptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (fe_queue_yumi_i),
    .set_v_i   (fe_queue_roll_i),
    .set_val_i (cptr),
    .ptr_o     (rptr)
  );

  bp_be_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) u_cptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (cptr_inc),
    .set_v_i   (1'b0),
    .set_val_i ('0),
    .ptr_o     (cptr)
  );

  always_ff @(posedge clk_i) begin
    if (enq & ~fe_queue_clr_i) begin
      mem[wptr[ptr_width_lp-2:0]] <= fe_queue_i;
    end
  end

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (fe_queue_yumi_i & ~fe_queue_roll_i) |-> fe_queue_v_o);
  a_deq_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_deq_i |-> (cptr != rptr));
  a_roll_deq_excl: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(fe_queue_roll_i & fe_queue_deq_i));

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Randomized and directed bench for the checkpointing FE queue against a queue-based model.
module tb_bp_be_fe_queue_ckpt;
  import bp_be_pkg::*;

  localparam int els_lp = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  bp_fe_queue_s fe_in;
  logic         v_in, yumi, clr, roll, deq;
  logic         ready, v_out;
  logic [fe_queue_width_lp-1:0] fe_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: q holds every entry from the commit point to the tail; issued counts
  // how many of those the scheduler has consumed but not yet committed.
  bp_fe_queue_s q[$];
  int           issued;

  bp_be_fe_queue_ckpt #(.els_p(els_lp)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .fe_queue_i       (fe_in),
    .fe_queue_v_i     (v_in),
    .fe_queue_ready_o (ready),
    .fe_queue_o       (fe_out),
    .fe_queue_v_o     (v_out),
    .fe_queue_yumi_i  (yumi),
    .fe_queue_clr_i   (clr),
    .fe_queue_roll_i  (roll),
    .fe_queue_deq_i   (deq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bp_fe_queue_s pk(input int n);
    bp_fe_queue_s p;
    p.msg_type = (n % 5 == 4) ? e_fe_exception : e_fe_fetch;
    p.pc       = 39'(64'h8000_0000 + 64'(n) * 4);
    p.instr    = 32'h0001_0013 ^ 32'(n * 32'h0101_0101);
    return p;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, 96'(ready), 96'(q.size() < els_lp));
    chk({tag, ".v"}, 96'(v_out), 96'(issued < q.size()));
    if (issued < q.size()) chk({tag, ".data"}, 96'(fe_out), 96'(q[issued]));
  endtask

  task automatic step(input string tag, input logic v, input bp_fe_queue_s d,
                      input logic y, input logic c, input logic r, input logic dq);
    logic enq_acc;
    int   new_iss;
    fe_in = d; v_in = v; yumi = y; clr = c; roll = r; deq = dq;
    enq_acc = v && (q.size() < els_lp);
    @(posedge clk);
    new_iss = r ? 0 : issued + int'(y);
    if (dq && !r) begin
      void'(q.pop_front());
      new_iss--;
    end
    if (c) begin
      while (q.size() > new_iss) void'(q.pop_back());
    end else if (enq_acc) begin
      q.push_back(d);
    end
    issued = new_iss;
    #1;
    v_in = 1'b0; yumi = 1'b0; clr = 1'b0; roll = 1'b0; deq = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    v_in = 1'b0; yumi = 1'b0; clr = 1'b0; roll = 1'b0; deq = 1'b0;
    fe_in = '0;
    q.delete();
    issued = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_model("reset");
  endtask

  task automatic enq(input string tag, input int n);
    step(tag, 1'b1, pk(n), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ctl(input string tag, input logic y, input logic c, input logic r, input logic dq);
    step(tag, 1'b0, '0, y, c, r, dq);
  endtask

  initial begin
    bp_fe_queue_s rp;
    logic rv, ry, rc, rr, rd;
    do_reset();
    chk("reset.v_abs", 96'(v_out), 96'(0));
    chk("reset.ready_abs", 96'(ready), 96'(1));

    // 1: fill to full
    for (int i = 0; i < 4; i++) begin
      chk("s1.ready_pre", 96'(ready), 96'(1));
      enq("s1.enq", i);
    end
    chk("s1.full", 96'(ready), 96'(0));
    chk("s1.head", 96'(fe_out), 96'(pk(0)));

    // 2: yumi A,B; deq A; roll -> replay from B
    do_reset();
    for (int i = 0; i < 4; i++) enq("s2.enq", i);
    ctl("s2.yumi", 1, 0, 0, 0);
    ctl("s2.yumi", 1, 0, 0, 0);
    ctl("s2.deq", 0, 0, 0, 1);
    ctl("s2.roll", 0, 0, 1, 0);
    chk("s2.head", 96'(fe_out), 96'(pk(1)));
    chk("s2.ready", 96'(ready), 96'(1));

    // 3: issue everything, then commit one slot and refill
    do_reset();
    for (int i = 0; i < 4; i++) enq("s3.enq", i);
    for (int i = 0; i < 4; i++) ctl("s3.yumi", 1, 0, 0, 0);
    chk("s3.v", 96'(v_out), 96'(0));
    chk("s3.full", 96'(ready), 96'(0));
    ctl("s3.deq", 0, 0, 0, 1);
    chk("s3.ready", 96'(ready), 96'(1));
    enq("s3.enqE", 4);
    chk("s3.headE", 96'(fe_out), 96'(pk(4)));

    // 4: clear drops unissued entries and a concurrent enqueue
    do_reset();
    for (int i = 0; i < 3; i++) enq("s4.enq", i);
    ctl("s4.yumi", 1, 0, 0, 0);
    step("s4.clr", 1'b1, pk(3), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s4.v", 96'(v_out), 96'(0));
    ctl("s4.deq", 0, 0, 0, 1);
    enq("s4.enqE", 4);
    chk("s4.headE", 96'(fe_out), 96'(pk(4)));
    ctl("s4.roll", 0, 0, 1, 0);
    chk("s4.rollE", 96'(fe_out), 96'(pk(4)));

    // 5: roll and clear together empty the queue to the commit point
    do_reset();
    for (int i = 0; i < 3; i++) enq("s5.enq", i);
    ctl("s5.yumi", 1, 0, 0, 0);
    ctl("s5.yumi", 1, 0, 0, 0);
    ctl("s5.rollclr", 0, 1, 1, 0);
    chk("s5.v", 96'(v_out), 96'(0));
    enq("s5.enqF", 5);
    chk("s5.headF", 96'(fe_out), 96'(pk(5)));

    // 6: streaming with simultaneous enq/yumi/deq across several wraps
    do_reset();
    enq("s6.enq", 0);
    step("s6.ey", 1'b1, pk(1), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) step("s6.stream", 1'b1, pk(i), 1'b1, 1'b0, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("s6.async_v", 96'(v_out), 96'(0));
    chk("s6.async_ready", 96'(ready), 96'(1));
    q.delete();
    issued = 0;
    @(negedge clk);
    reset_n = 1'b1;
    ctl("s6.post", 0, 0, 0, 0);
    chk("s6.no_stale", 96'(v_out), 96'(0));

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rp.msg_type = bp_fe_queue_type_e'($urandom_range(0, 1));
      rp.pc       = 39'({$urandom(), $urandom()});
      rp.instr    = $urandom();
      rv = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < 5);
      rc = ($urandom_range(0, 99) < 5);
      ry = (issued < q.size()) && ($urandom_range(0, 99) < 50);
      rd = (issued > 0) && !rr && ($urandom_range(0, 99) < 40);
      step("rand", rv, rp, ry, rc, rr, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
